// File: rtl/rv32_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV32I datapath.
// Walks each instruction through FETCH, DECODE, EXEC and WB, driving the
// register-file, ALU and PC controls. OP, OP-IMM, LUI, JAL and JALR execute;
// SYSTEM halts cleanly and any undecodable word halts with illegal set.
module rv32_ctrl_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  ra0,
  output logic [4:0]  ra1,
  output logic [4:0]  wa,
  output logic        wr_en,
  output logic [3:0]  alu_op,
  output logic [1:0]  src_a_sel,
  output logic        src_b_sel,
  output logic [31:0] imm,
  output logic        wb_sel,
  output logic        pc_we,
  output logic        jump,
  output logic        pc_lsb_clr,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    WB,
    HALT
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  state_t      state;
  logic [31:0] ir;

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  logic [3:0]  dec_alu_op;
  logic [1:0]  dec_src_a;
  logic        dec_src_b;
  logic [31:0] dec_imm;
  logic        dec_wb_sel;
  logic        dec_jump;
  logic        dec_lsb_clr;
  logic        dec_legal;
  logic        dec_system;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];
  assign imm_i  = {{20{ir[31]}}, ir[31:20]};
  assign imm_u  = {ir[31:12], 12'b0};
  assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  assign imem_req = (state == FETCH);

  // funct3 selects the ALU operation; alt picks SUB/SRA over ADD/SRL
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Decode the latched instruction into datapath controls and a legality verdict
  always_comb begin
    dec_alu_op  = ALU_ADD;
    dec_src_a   = 2'd0;
    dec_src_b   = 1'b0;
    dec_imm     = 32'd0;
    dec_wb_sel  = 1'b0;
    dec_jump    = 1'b0;
    dec_lsb_clr = 1'b0;
    dec_legal   = 1'b0;
    dec_system  = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_legal  = (funct7 == 7'h00) ||
                     ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        dec_alu_op = alu_from_f3(funct3, funct7[5]);
      end
      OPC_OP_IMM: begin
        dec_src_b  = 1'b1;
        dec_imm    = imm_i;
        case (funct3)
          3'b001:  dec_legal = (funct7 == 7'h00);
          3'b101:  dec_legal = (funct7 == 7'h00) || (funct7 == 7'h20);
          default: dec_legal = 1'b1;
        endcase
        dec_alu_op = alu_from_f3(funct3, (funct3 == 3'b101) && funct7[5]);
      end
      OPC_LUI: begin
        dec_legal = 1'b1;
        dec_src_a = 2'd2;
        dec_src_b = 1'b1;
        dec_imm   = imm_u;
      end
      OPC_JAL: begin
        dec_legal  = 1'b1;
        dec_src_a  = 2'd1;
        dec_src_b  = 1'b1;
        dec_imm    = imm_j;
        dec_wb_sel = 1'b1;
        dec_jump   = 1'b1;
      end
      OPC_JALR: begin
        dec_legal   = (funct3 == 3'b000);
        dec_src_b   = 1'b1;
        dec_imm     = imm_i;
        dec_wb_sel  = 1'b1;
        dec_jump    = 1'b1;
        dec_lsb_clr = 1'b1;
      end
      OPC_SYSTEM: begin
        dec_legal  = 1'b1;
        dec_system = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Sequencer: state, instruction register and every registered control output
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ir         <= 32'd0;
      ra0        <= 5'd0;
      ra1        <= 5'd0;
      wa         <= 5'd0;
      wr_en      <= 1'b0;
      alu_op     <= ALU_ADD;
      src_a_sel  <= 2'd0;
      src_b_sel  <= 1'b0;
      imm        <= 32'd0;
      wb_sel     <= 1'b0;
      pc_we      <= 1'b0;
      jump       <= 1'b0;
      pc_lsb_clr <= 1'b0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
      instret    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (run) state <= FETCH;
        end
        FETCH: begin
          if (imem_ack) begin
            ir    <= imem_rdata;
            state <= DECODE;
          end
        end
        DECODE: begin
          if (dec_system) begin
            halted <= 1'b1;
            state  <= HALT;
          end else if (!dec_legal) begin
            halted  <= 1'b1;
            illegal <= 1'b1;
            state   <= HALT;
          end else begin
            ra0        <= rs1;
            ra1        <= rs2;
            wa         <= rd;
            alu_op     <= dec_alu_op;
            src_a_sel  <= dec_src_a;
            src_b_sel  <= dec_src_b;
            imm        <= dec_imm;
            wb_sel     <= dec_wb_sel;
            jump       <= dec_jump;
            pc_lsb_clr <= dec_lsb_clr;
            state      <= EXEC;
          end
        end
        EXEC: begin
          wr_en <= (wa != 5'd0);
          pc_we <= 1'b1;
          state <= WB;
        end
        WB: begin
          wr_en   <= 1'b0;
          pc_we   <= 1'b0;
          instret <= instret + 32'd1;
          state   <= FETCH;
        end
        HALT: begin
          wr_en <= 1'b0;
          pc_we <= 1'b0;
          state <= HALT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
